tag_ctrl: RTL
=============

# tag_ctrl

Sequencer for the 4-way, 256-set cache tag blockram (18-bit tags, one-tag write port, 72-bit whole-set read port). Accepts lookups and line fills from the cache miss logic, drives the blockram ports, compares all four ways, and reports hit/way. It owns per-way valid bits and per-set replacement state, which the blockram cannot hold. It sits between the cache pipeline and the tag blockram, one instance per cache.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- OFF_W, 6, line offset bits (ignored)
- IDX_W, 8, set index bits; tag width is ADDR_W-IDX_W-OFF_W = 18

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when valid&ready
- req_addr  in  ADDR_W  lookup address
- resp_valid  out  1  one-cycle lookup result pulse, no backpressure
- resp_hit  out  1  tag matched a valid way
- resp_way  out  2  matching way (0 on miss)
- fill_valid  in  1  fill request
- fill_ready  out  1  fill accepted when valid&ready
- fill_addr  in  ADDR_W  address being filled
- fill_done  out  1  one-cycle pulse, tag written
- fill_way  out  2  way chosen, valid with fill_done
- flush  in  1  invalidate all ways
- ram_r_index  out  8  blockram read set
- ram_w_index  out  10  blockram write entry {set, way}
- ram_tag_in  out  18  blockram write data
- ram_wr_en  out  1  blockram write enable
- ram_tag_out  in  72  blockram read data, way w in bits [18w+17:18w], valid one cycle after ram_r_index

## Operation
- Address split: tag = addr[31:14], index = addr[13:6].
- FSM states: IDLE, RD, RESP, FILL.
- IDLE: req_ready = fill_ready = 1 unless flush is high. Priority: flush > fill > lookup. ram_r_index driven combinationally from req_addr index.
- flush in IDLE: clears all 1024 valid bits and all replacement state in that cycle; no request accepted; stays IDLE. flush outside IDLE is ignored (caller holds it).
- Lookup accept: register tag/index, go RD. RD: compare ram_tag_out against registered tag per way, gated by valid; lowest matching way wins; register result, update replacement state on hit; go RESP. RESP: resp_valid = 1; go IDLE.
- Fill accept: register tag/index, choose victim (lowest invalid way, else replacement policy), go FILL. FILL: ram_wr_en = 1, ram_w_index = {index, victim}, ram_tag_in = tag; set valid; update replacement state as access to victim; fill_done = 1; go IDLE.
- Fill to a tag already present is not checked; caller guarantees no duplicates.
- ram_wr_en is 1 only in FILL.

## Timing
- Reset: state IDLE, valids 0, replacement state 0, resp_valid/resp_hit/resp_way/fill_done/fill_way/ram_wr_en 0; reset mid-operation aborts without response or write.
- Lookup: accept cycle N, resp_valid cycle N+2; next accept earliest N+3.
- Fill: accept cycle N, write and fill_done cycle N+1; next accept earliest N+2.
- Lookup and fill both valid in IDLE: fill accepted, req_ready 0 that cycle.
- A fill at cycle N+1 is visible to a lookup accepted at N+2.

## Configuration
- TAG_CTRL_PLRU_EN defined: 3-bit tree pseudo-LRU per set. Victim = b0 ? {1,b2} : {0,b1}. Access to way w: b0 = ~w[1]; if w[1]=0 b1 = ~w[0], else b2 = ~w[0]. Hits and fills update.
- Undefined: one global 2-bit round-robin counter, used and incremented only on fills where all four ways are valid; hits do not update; no per-set state.

## Structure
- tag_ctrl_pkg: width localparams, state enum, tag/index extract functions.
- Sub-module tag_victim_sel: invalid-way priority pick, PLRU/round-robin selection, and update logic, with the macro confined to it.

## Test plan
- Reset then lookup 0x0000_1040 -> resp_valid at N+2, resp_hit 0, resp_way 0.
- Fill 0x1234_5678 -> fill_done at N+1, fill_way 0, ram_w_index = {0x59,2'b00}, ram_tag_in = 0x048D1; lookup same -> hit, way 0.
- Fill 5 distinct tags into set 0x10 (PLRU_EN, no intervening hits) -> ways 0,1,2,3 then 5th evicts way 0; lookup first tag -> miss.
- Same as above but hit way 0 before 5th fill -> 5th fill evicts way 2.
- Simultaneous fill_valid and req_valid in IDLE -> fill accepted, lookup accepted 2 cycles later and hits the new tag.
- Fill, then flush, then lookup same address -> miss; rst_n low during RD -> no resp_valid.

Source files
------------

// File: rtl/tag_ctrl_pkg.sv
// Shared widths, FSM state type and address-field helpers for the
// 4-way / 256-set cache tag sequencer.
package tag_ctrl_pkg;

  localparam int unsigned TC_ADDR_W = 32;
  localparam int unsigned TC_OFF_W  = 6;
  localparam int unsigned TC_IDX_W  = 8;
  localparam int unsigned TAG_W     = TC_ADDR_W - TC_IDX_W - TC_OFF_W;
  localparam int unsigned WAYS      = 4;
  localparam int unsigned WAY_W     = 2;
  localparam int unsigned SETS      = 1 << TC_IDX_W;

  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [TC_IDX_W-1:0]  idx_t;
  typedef logic [WAY_W-1:0]     way_t;
  typedef logic [WAYS-1:0]      vmask_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RESP,
    FILL
  } state_t;

  function automatic tag_t addr_tag(input logic [TC_ADDR_W-1:0] addr);
    return addr[TC_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_index(input logic [TC_ADDR_W-1:0] addr);
    return addr[TC_OFF_W +: TC_IDX_W];
  endfunction

  // Lowest set bit of a way mask; 0 when the mask is empty.
  function automatic way_t first_set(input vmask_t m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else if (m[3]) return 2'd3;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/tag_ctrl_if.sv
// Cache-side request/fill handshakes plus the tag blockram port bundle.
// slave = tag_ctrl, master = cache pipeline and blockram.
interface tag_ctrl_if #(
  parameter int ADDR_W = 32
);
  import tag_ctrl_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic                    resp_valid;
  logic                    resp_hit;
  way_t                    resp_way;
  logic                    fill_valid;
  logic                    fill_ready;
  logic [ADDR_W-1:0]       fill_addr;
  logic                    fill_done;
  way_t                    fill_way;
  logic                    flush;
  idx_t                    ram_r_index;
  logic [TC_IDX_W+WAY_W-1:0] ram_w_index;
  tag_t                    ram_tag_in;
  logic                    ram_wr_en;
  logic [WAYS*TAG_W-1:0]   ram_tag_out;

  modport slave (
    input  req_valid, req_addr, fill_valid, fill_addr, flush, ram_tag_out,
    output req_ready, resp_valid, resp_hit, resp_way,
           fill_ready, fill_done, fill_way,
           ram_r_index, ram_w_index, ram_tag_in, ram_wr_en
  );

  modport master (
    output req_valid, req_addr, fill_valid, fill_addr, flush, ram_tag_out,
    input  req_ready, resp_valid, resp_hit, resp_way,
           fill_ready, fill_done, fill_way,
           ram_r_index, ram_w_index, ram_tag_in, ram_wr_en
  );

endinterface

// File: rtl/tag_ctrl_victim_sel.sv
// Fill victim choice and replacement-state upkeep. TAG_CTRL_PLRU_EN selects
// per-set 3-bit tree PLRU; otherwise a single global round-robin counter.
module tag_victim_sel
  import tag_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   pick_en,
  input  idx_t   pick_index,
  input  vmask_t pick_valid,
  output way_t   victim,
  input  logic   upd_en,
  input  idx_t   upd_index,
  input  way_t   upd_way
);

  way_t pol_way;

`ifdef TAG_CTRL_PLRU_EN
  // bit0 = root, bit1 = left pair (ways 0/1), bit2 = right pair (ways 2/3)
  logic [2:0] plru_q [SETS];
  logic [2:0] plru_cur;
  logic [2:0] plru_nxt;
  logic       unused_pick;

  assign unused_pick = pick_en;
  assign plru_cur    = plru_q[pick_index];
  assign pol_way     = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};

  always_comb begin
    plru_nxt    = plru_q[upd_index];
    plru_nxt[0] = ~upd_way[1];
    if (!upd_way[1]) plru_nxt[1] = ~upd_way[0];
    else             plru_nxt[2] = ~upd_way[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int unsigned s = 0; s < SETS; s++) plru_q[idx_t'(s)] <= '0;
    end else if (upd_en) begin
      plru_q[upd_index] <= plru_nxt;
    end
  end
`else
  way_t rr_q;
  logic unused_upd;

  assign unused_upd = ^{upd_en, upd_index, upd_way, pick_index};
  assign pol_way    = rr_q;

  // Advances only when the policy actually supplied the victim.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) rr_q <= '0;
    else if (pick_en && (&pick_valid)) rr_q <= rr_q + 2'd1;
  end
`endif

  assign victim = (&pick_valid) ? pol_way : first_set(~pick_valid);

endmodule

// File: rtl/tag_ctrl.sv
// Tag blockram sequencer: lookup/fill FSM, way compare, per-way valid bits.
// Replacement policy lives in tag_victim_sel (TAG_CTRL_PLRU_EN).
module tag_ctrl #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 6,
  parameter int IDX_W  = 8
) (
  input logic        clk,
  input logic        rst_n,
  tag_ctrl_if.slave  bus
);
  import tag_ctrl_pkg::*;

  state_t state_q, state_d;

  logic [ADDR_W-IDX_W-OFF_W-1:0] tag_q;
  logic [IDX_W-1:0]              idx_q;
  way_t                          way_q;
  logic                          hit_q;
  logic [SETS*WAYS-1:0]          valid_q;

  idx_t   fill_idx;
  vmask_t set_valid;
  vmask_t pick_valid;
  vmask_t hit_mask;
  way_t   victim;
  logic   fill_acc;
  logic   req_acc;
  logic   clear;
  logic   upd_en;
  way_t   upd_way;

  assign fill_idx        = addr_index(bus.fill_addr);
  assign bus.ram_r_index = addr_index(bus.req_addr);
  assign set_valid       = valid_q[{idx_q, 2'b00} +: WAYS];
  assign pick_valid      = valid_q[{fill_idx, 2'b00} +: WAYS];
  assign clear           = (state_q == IDLE) && bus.flush;

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign hit_mask[g] = set_valid[g] && (bus.ram_tag_out[g*TAG_W +: TAG_W] == tag_q);
  end

  tag_victim_sel u_victim (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .pick_en    (fill_acc),
    .pick_index (fill_idx),
    .pick_valid (pick_valid),
    .victim     (victim),
    .upd_en     (upd_en),
    .upd_index  (idx_q),
    .upd_way    (upd_way)
  );

  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.fill_ready  = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_hit    = 1'b0;
    bus.resp_way    = '0;
    bus.fill_done   = 1'b0;
    bus.fill_way    = '0;
    bus.ram_wr_en   = 1'b0;
    bus.ram_w_index = '0;
    bus.ram_tag_in  = '0;
    fill_acc        = 1'b0;
    req_acc         = 1'b0;
    upd_en          = 1'b0;
    upd_way         = '0;
    case (state_q)
      IDLE: begin
        // Fill wins over lookup, so a competing lookup is held off this cycle.
        if (!bus.flush) begin
          bus.fill_ready = 1'b1;
          bus.req_ready  = !bus.fill_valid;
          if (bus.fill_valid) begin
            fill_acc = 1'b1;
            state_d  = FILL;
          end else if (bus.req_valid) begin
            req_acc = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        upd_en  = |hit_mask;
        upd_way = first_set(hit_mask);
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_hit   = hit_q;
        bus.resp_way   = way_q;
        state_d        = IDLE;
      end
      FILL: begin
        bus.ram_wr_en   = 1'b1;
        bus.ram_w_index = {idx_q, way_q};
        bus.ram_tag_in  = tag_q;
        bus.fill_done   = 1'b1;
        bus.fill_way    = way_q;
        upd_en          = 1'b1;
        upd_way         = way_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_acc) begin
        tag_q <= addr_tag(bus.fill_addr);
        idx_q <= fill_idx;
        way_q <= victim;
      end else if (req_acc) begin
        tag_q <= addr_tag(bus.req_addr);
        idx_q <= addr_index(bus.req_addr);
      end
      if (state_q == RD) begin
        hit_q <= |hit_mask;
        way_q <= first_set(hit_mask);
      end
      if (clear) valid_q <= '0;
      else if (state_q == FILL) valid_q[{idx_q, way_q}] <= 1'b1;
    end
  end

endmodule
